// File: rtl/iic_slave_responder.sv
// IIC target that ACKs SLAVE_ADDR, takes a register pointer plus write data,
// and serves auto-incrementing register reads. All logic runs on sys_clk.
module iic_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         REG_AW     = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              scl,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              wr_valid,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int DEPTH = 2 ** REG_AW;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        scl_pipe_q, scl_pipe_d;
  logic [2:0]        sda_pipe_q, sda_pipe_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [REG_AW-1:0] ptr_q, ptr_d;
  logic [7:0]        regs_q [DEPTH];
  logic [7:0]        regs_d [DEPTH];
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              rw_q, rw_d;
  logic              ack_seen_q, ack_seen_d;
  logic              wr_pend_q, wr_pend_d;
  logic              wr_valid_q, wr_valid_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic              scl_s, scl_d, sda_s, sda_d;
  logic              scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]        rx_byte;
  logic [REG_AW-1:0] ptr_inc;

  // Bits [1:0] are the synchronizer, bit 2 is the one-cycle history.
  assign scl_s     = scl_pipe_q[1];
  assign scl_d     = scl_pipe_q[2];
  assign sda_s     = sda_pipe_q[1];
  assign sda_d     = sda_pipe_q[2];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  always_comb begin
    scl_pipe_d = {scl_pipe_q[1:0], scl};
    sda_pipe_d = {sda_pipe_q[1:0], sda_in};
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    regs_d     = regs_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    ack_seen_d = ack_seen_q;
    wr_pend_d  = 1'b0;
    wr_valid_d = wr_pend_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rx_byte    = {shift_q[6:0], sda_s};
    ptr_inc    = ptr_q + 1'b1;

    if (stop_det) begin
      state_d    = IDLE;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      bit_cnt_d  = 4'd0;
      ack_seen_d = 1'b0;
    end else if (start_det) begin
      state_d    = ADDR;
      sda_oe_d   = 1'b0;
      bit_cnt_d  = 4'd0;
      shift_d    = 8'd0;
      ack_seen_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d = ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = IGNORE;
                end
              end else if (state_q == PTR) begin
                ptr_d   = rx_byte[REG_AW-1:0];
                state_d = PTR_ACK;
              end else begin
                regs_d[ptr_q] = rx_byte;
                wr_pend_d     = 1'b1;
                wr_addr_d     = ptr_q;
                wr_data_d     = rx_byte;
                ptr_d         = ptr_inc;
                state_d       = WDATA_ACK;
              end
            end
          end
        end
        // sda_oe doubles as the phase flag: low = ACK not yet driven.
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              if (state_q == ADDR_ACK && rw_q) begin
                state_d  = RDATA;
                shift_d  = regs_q[ptr_q];
                sda_oe_d = ~regs_q[ptr_q][7];
              end else if (state_q == ADDR_ACK) begin
                state_d = PTR;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              sda_oe_d   = 1'b0;
              bit_cnt_d  = 4'd0;
              ack_seen_d = 1'b0;
              state_d    = RDATA_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        RDATA_ACK: begin
          if (!ack_seen_q && scl_rise) begin
            ptr_d = ptr_inc;
            if (!sda_s) begin
              ack_seen_d = 1'b1;
              shift_d    = regs_q[ptr_inc];
            end else begin
              state_d = IGNORE;
            end
          end else if (ack_seen_q && scl_fall) begin
            ack_seen_d = 1'b0;
            bit_cnt_d  = 4'd0;
            sda_oe_d   = ~shift_q[7];
            state_d    = RDATA;
          end
        end
        default: begin
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // Synchronizers reset high to match an idle bus and avoid spurious edges.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      scl_pipe_q <= 3'b111;
      sda_pipe_q <= 3'b111;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      ptr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'd0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      ack_seen_q <= 1'b0;
      wr_pend_q  <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      scl_pipe_q <= scl_pipe_d;
      sda_pipe_q <= sda_pipe_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      regs_q     <= regs_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      ack_seen_q <= ack_seen_d;
      wr_pend_q  <= wr_pend_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_iic_slave_responder.sv
// Bit-banged IIC master driving iic_slave_responder, with a register-file
// model and a write scoreboard drained by a wr_valid monitor.
module tb_iic_slave_responder;

  localparam int Q = 8;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_oe, wr_valid, busy;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  wire        sda_bus = sda_drv & ~sda_oe;

  int          assertCount = 0;
  int          failCount = 0;
  logic [7:0]  modelRegs [16];
  int          modelPtr = 0;
  logic [11:0] wrExpQ [$];
  logic [7:0]  wrData [$];
  logic        oeSeen = 1'b0;

  iic_slave_responder #(.SLAVE_ADDR(7'h50), .REG_AW(4)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .scl     (scl),
    .sda_in  (sda_bus),
    .sda_oe  (sda_oe),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard drain: every wr_valid beat must match the oldest expected write.
  always @(negedge sys_clk) begin
    if (sda_oe) oeSeen = 1'b1;
    if (!sys_rst && wr_valid) begin
      if (wrExpQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_wr_valid: got addr %0d data 0x%0h, expected none",
                 wr_addr, wr_data);
      end else begin
        checkOutput("wr_beat", {20'd0, wr_addr, wr_data}, {20'd0, wrExpQ.pop_front()});
      end
    end
  end

  initial begin
    repeat (100000) @(posedge sys_clk);
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic qWait();
    repeat (Q) @(negedge sys_clk);
  endtask

  task automatic busStart();
    sda_drv = 1'b0; qWait();
    scl = 1'b0; qWait();
  endtask

  task automatic busRestart();
    sda_drv = 1'b1; qWait();
    scl = 1'b1; qWait();
    sda_drv = 1'b0; qWait();
    scl = 1'b0; qWait();
  endtask

  task automatic busStop();
    sda_drv = 1'b0; qWait();
    scl = 1'b1; qWait();
    sda_drv = 1'b1; qWait();
  endtask

  task automatic busBit(input logic b, output logic sampled);
    sda_drv = b; qWait();
    scl = 1'b1; qWait();
    sampled = sda_bus; qWait();
    scl = 1'b0; qWait();
  endtask

  task automatic busWriteByte(input logic [7:0] b, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) busBit(b[i], dummy);
    busBit(1'b1, ack);
  endtask

  task automatic busReadByte(input logic nack, output logic [7:0] b);
    logic dummy;
    for (int i = 7; i >= 0; i--) busBit(1'b1, b[i]);
    busBit(nack, dummy);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) modelRegs[i] = 8'h00;
    modelPtr = 0;
  endtask

  // One full transaction; write payload comes from wrData, read results are
  // compared against the register model.
  task automatic applyStimulus(input logic [6:0] devAddr, input bit doRead,
                               input bit setPtr, input logic [7:0] ptrVal,
                               input int nBytes);
    logic       ack;
    logic [7:0] got, exp;
    bit         matched = (devAddr == 7'h50);
    oeSeen = 1'b0;
    busStart();
    busWriteByte({devAddr, doRead && !setPtr}, ack);
    checkOutput("addr_ack", {31'd0, ack}, {31'd0, !matched});
    if (!matched) begin
      if (setPtr) begin
        busWriteByte(ptrVal, ack);
        checkOutput("mismatch_data_nack", {31'd0, ack}, 32'd1);
      end
      checkOutput("mismatch_busy", {31'd0, busy}, 32'd0);
      busStop();
      checkOutput("mismatch_oe_seen", {31'd0, oeSeen}, 32'd0);
      return;
    end
    checkOutput("busy_after_addr", {31'd0, busy}, 32'd1);
    if (setPtr) begin
      busWriteByte(ptrVal, ack);
      checkOutput("ptr_ack", {31'd0, ack}, 32'd0);
      modelPtr = ptrVal % 16;
    end
    if (!doRead) begin
      foreach (wrData[i]) begin
        wrExpQ.push_back({modelPtr[3:0], wrData[i]});
        modelRegs[modelPtr] = wrData[i];
        modelPtr = (modelPtr + 1) % 16;
        busWriteByte(wrData[i], ack);
        checkOutput("data_ack", {31'd0, ack}, 32'd0);
      end
    end else begin
      if (setPtr) begin
        busRestart();
        busWriteByte({devAddr, 1'b1}, ack);
        checkOutput("raddr_ack", {31'd0, ack}, 32'd0);
      end
      for (int i = 0; i < nBytes; i++) begin
        exp = modelRegs[modelPtr];
        modelPtr = (modelPtr + 1) % 16;
        busReadByte(i == nBytes - 1, got);
        checkOutput("read_byte", {24'd0, got}, {24'd0, exp});
      end
    end
    busStop();
    repeat (4) @(negedge sys_clk);
    checkOutput("busy_after_stop", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic       ack;
    logic [6:0] addr;
    bit         rd, sp;
    $display("[TB] start");
    modelReset();
    repeat (4) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    checkOutput("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
    checkOutput("reset_wr_valid", {31'd0, wr_valid}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_wr_addr_data", {20'd0, wr_addr, wr_data}, 32'd0);
    repeat (4) @(negedge sys_clk);

    wrData = '{8'h5A, 8'hC3};
    applyStimulus(7'h50, 1'b0, 1'b1, 8'h03, 0);
    applyStimulus(7'h50, 1'b1, 1'b1, 8'h03, 2);
    applyStimulus(7'h50, 1'b1, 1'b0, 8'h00, 1);
    applyStimulus(7'h51, 1'b0, 1'b1, 8'h11, 0);
    wrData = '{8'h11, 8'h22};
    applyStimulus(7'h50, 1'b0, 1'b1, 8'h0F, 0);
    applyStimulus(7'h50, 1'b1, 1'b1, 8'hFF, 2);

    // Reset while the slave is driving bit 7 of reg 3 (0x5A, a zero bit).
    busStart();
    busWriteByte(8'hA0, ack);
    busWriteByte(8'h03, ack);
    busRestart();
    busWriteByte(8'hA1, ack);
    checkOutput("rst_raddr_ack", {31'd0, ack}, 32'd0);
    qWait();
    checkOutput("oe_before_reset", {31'd0, sda_oe}, 32'd1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    checkOutput("oe_after_reset", {31'd0, sda_oe}, 32'd0);
    checkOutput("busy_after_reset", {31'd0, busy}, 32'd0);
    sys_rst = 1'b0;
    modelReset();
    busStop();
    applyStimulus(7'h50, 1'b1, 1'b1, 8'h03, 1);

    for (int t = 0; t < 20; t++) begin
      addr = 7'h50;
      if ($urandom_range(0, 4) == 0) begin
        do addr = 7'($urandom); while (addr == 7'h50);
      end
      rd = $urandom_range(0, 1) == 1;
      sp = rd ? ($urandom_range(0, 1) == 1) : 1'b1;
      wrData.delete();
      for (int i = $urandom_range(1, 3); i > 0; i--) wrData.push_back(8'($urandom));
      applyStimulus(addr, rd, sp, 8'($urandom), $urandom_range(1, 3));
    end

    repeat (20) @(negedge sys_clk);
    checkOutput("wr_queue_drained", wrExpQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
